blackjack_game_ctrl: RTL and testbench



---
 rtl/bj_pkg.sv | 51 +++++
 rtl/bj_hand_acc.sv | 38 +++
 rtl/blackjack_game_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_blackjack_game_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bj_pkg.sv
// Shared encodings, result codes and card helpers for the blackjack sequencer.
package bj_pkg;

  typedef enum logic [3:0] {
    ST_SHUFFLE     = 4'd0,
    ST_DEAL_P1     = 4'd1,
    ST_DEAL_D1     = 4'd2,
    ST_DEAL_P2     = 4'd3,
    ST_DEAL_D2     = 4'd4,
    ST_PLAYER_TURN = 4'd5,
    ST_PLAYER_DRAW = 4'd6,
    ST_DEALER_TURN = 4'd7,
    ST_DEALER_DRAW = 4'd8,
    ST_RESULT      = 4'd9
  } bj_state_t;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  localparam logic [4:0] BJ_LIMIT  = 5'd21;
  localparam logic [4:0] ACE_BONUS = 5'd10;

  // 0 is read as an ace, anything above 10 as a ten-valued card.
  function automatic logic [4:0] norm_card(input logic [3:0] value);
    logic [4:0] v;
    if (value == 4'd0)
      v = 5'd1;
    else if (value > 4'd10)
      v = 5'd10;
    else
      v = {1'b0, value};
    return v;
  endfunction

  function automatic logic [1:0] decide_result(input logic [4:0] player,
                                               input logic [4:0] dealer);
    logic [1:0] r;
    if (dealer > BJ_LIMIT)
      r = RES_PLAYER;
    else if (player > dealer)
      r = RES_PLAYER;
    else if (dealer > player)
      r = RES_DEALER;
    else
      r = RES_PUSH;
    return r;
  endfunction

endpackage

// File: rtl/bj_hand_acc.sv
// One blackjack hand: hard sum with aces as 1, an ace flag and a saturating card count.
module bj_hand_acc
  import bj_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       add,
  input  logic [3:0] value,
  output logic [4:0] total,
  output logic       bust,
  output logic [3:0] count
);

  logic [4:0] hard;
  logic       ace;
  logic [4:0] card;

  assign card = norm_card(value);

  always_ff @(posedge clk) begin
    if (clear) begin
      hard  <= 5'd0;
      ace   <= 1'b0;
      count <= 4'd0;
    end else if (add) begin
      hard <= hard + card;
      if (card == 5'd1)
        ace <= 1'b1;
      if (count != 4'hf)
        count <= count + 4'd1;
    end
  end

  // One ace may count as 11 only while that keeps the hand at or under 21.
  assign total = (ace && hard <= (BJ_LIMIT - ACE_BONUS)) ? hard + ACE_BONUS : hard;
  assign bust  = (total > BJ_LIMIT);

endmodule

// File: rtl/blackjack_game_ctrl.sv
// Blackjack round sequencer: shuffle, deal, player hit/stay, dealer draw-to-stand, result.
//
// state           | meaning
// ST_SHUFFLE      | pulse shuffle_start, wait for shuffle_done
// ST_DEAL_P1..D2  | draw one card to player/dealer, then pace GAME_TIMER cycles
// ST_PLAYER_TURN  | wait for hit or stay (stay wins a tie)
// ST_PLAYER_DRAW  | draw one player card, then check bust / 21
// ST_DEALER_TURN  | pace GAME_TIMER cycles, then draw or stand
// ST_DEALER_DRAW  | draw one dealer card
// ST_RESULT       | hold result and totals until new_game_pulse
module blackjack_game_ctrl
  import bj_pkg::*;
#(
  parameter logic [26:0] GAME_TIMER   = 27'd50_000_000,
  parameter logic [4:0]  DEALER_STAND = 5'd17
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       hit_pulse,
  input  logic       stay_pulse,
  input  logic       new_game_pulse,
  output logic       shuffle_start,
  input  logic       shuffle_done,
  output logic       card_req,
  input  logic       card_valid,
  input  logic [3:0] card_value,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic [3:0] player_cards,
  output logic [3:0] state_code,
  output logic [1:0] result
);

  localparam logic [26:0] TIMER_LAST = (GAME_TIMER == 27'd0) ? 27'd0 : GAME_TIMER - 27'd1;

  bj_state_t   state;
  logic [26:0] timer;
  logic        drawn;
  logic        armed;
  logic        card_taken;
  logic        player_add;
  logic        dealer_add;
  logic        hand_clear;
  logic        timer_done;
  logic        player_bust;
  logic        dealer_bust;
  logic [3:0]  dealer_cards;

  assign card_taken = card_req && card_valid;
  assign player_add = card_taken && (state == ST_DEAL_P1 || state == ST_DEAL_P2 ||
                                     state == ST_PLAYER_DRAW);
  assign dealer_add = card_taken && (state == ST_DEAL_D1 || state == ST_DEAL_D2 ||
                                     state == ST_DEALER_DRAW);
  assign hand_clear = reset || (state == ST_RESULT && new_game_pulse);
  assign timer_done = (timer == TIMER_LAST);
  assign state_code = state;

  bj_hand_acc u_player (
    .clk   (CLOCK_50),
    .clear (hand_clear),
    .add   (player_add),
    .value (card_value),
    .total (player_total),
    .bust  (player_bust),
    .count (player_cards)
  );

  bj_hand_acc u_dealer (
    .clk   (CLOCK_50),
    .clear (hand_clear),
    .add   (dealer_add),
    .value (card_value),
    .total (dealer_total),
    .bust  (dealer_bust),
    .count (dealer_cards)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= ST_SHUFFLE;
      timer         <= 27'd0;
      drawn         <= 1'b0;
      armed         <= 1'b1;
      shuffle_start <= 1'b0;
      card_req      <= 1'b0;
      result        <= RES_NONE;
    end else begin
      shuffle_start <= 1'b0;
      if (card_taken) begin
        card_req <= 1'b0;
        drawn    <= 1'b1;
      end

      case (state)
        ST_SHUFFLE: begin
          if (armed) begin
            shuffle_start <= 1'b1;
            armed         <= 1'b0;
          end else if (shuffle_done) begin
            state    <= ST_DEAL_P1;
            card_req <= 1'b1;
            drawn    <= 1'b0;
            timer    <= 27'd0;
          end
        end

        // Pacing starts only once the card has actually arrived.
        ST_DEAL_P1, ST_DEAL_D1, ST_DEAL_P2: begin
          if (drawn) begin
            if (timer_done) begin
              state    <= (state == ST_DEAL_P1) ? ST_DEAL_D1 :
                          (state == ST_DEAL_D1) ? ST_DEAL_P2 : ST_DEAL_D2;
              card_req <= 1'b1;
              drawn    <= 1'b0;
              timer    <= 27'd0;
            end else begin
              timer <= timer + 27'd1;
            end
          end
        end

        ST_DEAL_D2: begin
          if (drawn) begin
            if (timer_done) begin
              state <= (player_total == BJ_LIMIT) ? ST_DEALER_TURN : ST_PLAYER_TURN;
              timer <= 27'd0;
            end else begin
              timer <= timer + 27'd1;
            end
          end
        end

        ST_PLAYER_TURN: begin
          if (stay_pulse) begin
            state <= ST_DEALER_TURN;
            timer <= 27'd0;
          end else if (hit_pulse) begin
            state    <= ST_PLAYER_DRAW;
            card_req <= 1'b1;
            drawn    <= 1'b0;
            timer    <= 27'd0;
          end
        end

        ST_PLAYER_DRAW: begin
          if (drawn) begin
            timer <= 27'd0;
            if (player_bust) begin
              state  <= ST_RESULT;
              result <= RES_DEALER;
            end else if (player_total == BJ_LIMIT) begin
              state <= ST_DEALER_TURN;
            end else begin
              state <= ST_PLAYER_TURN;
            end
          end
        end

        // A saturated card count also stops the dealer so the count stays truthful.
        ST_DEALER_TURN: begin
          if (timer_done) begin
            timer <= 27'd0;
            if (dealer_total < DEALER_STAND && dealer_cards != 4'hf) begin
              state    <= ST_DEALER_DRAW;
              card_req <= 1'b1;
              drawn    <= 1'b0;
            end else begin
              state  <= ST_RESULT;
              result <= dealer_bust ? RES_PLAYER : decide_result(player_total, dealer_total);
            end
          end else begin
            timer <= timer + 27'd1;
          end
        end

        ST_DEALER_DRAW: begin
          if (card_taken) begin
            state <= ST_DEALER_TURN;
            timer <= 27'd0;
          end
        end

        ST_RESULT: begin
          if (new_game_pulse) begin
            state  <= ST_SHUFFLE;
            result <= RES_NONE;
            armed  <= 1'b1;
            timer  <= 27'd0;
          end
        end

        default: begin
          state    <= ST_SHUFFLE;
          card_req <= 1'b0;
          armed    <= 1'b1;
          timer    <= 27'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blackjack_game_ctrl.sv
// Directed bench for blackjack_game_ctrl with a scripted deck and hand-computed expectations.
module tb_blackjack_game_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       hit_pulse = 1'b0;
  logic       stay_pulse = 1'b0;
  logic       new_game_pulse = 1'b0;
  logic       shuffle_start;
  logic       shuffle_done = 1'b0;
  logic       card_req;
  logic       card_valid = 1'b0;
  logic [3:0] card_value = 4'd0;
  logic [4:0] player_total;
  logic [4:0] dealer_total;
  logic [3:0] player_cards;
  logic [3:0] state_code;
  logic [1:0] result;

  int tests = 0;
  int fails = 0;

  localparam int S_SHUFFLE = 0;
  localparam int S_PTURN   = 5;
  localparam int S_DTURN   = 7;
  localparam int S_DDRAW   = 8;
  localparam int S_RESULT  = 9;

  blackjack_game_ctrl #(.GAME_TIMER(27'd10), .DEALER_STAND(5'd17)) dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .hit_pulse      (hit_pulse),
    .stay_pulse     (stay_pulse),
    .new_game_pulse (new_game_pulse),
    .shuffle_start  (shuffle_start),
    .shuffle_done   (shuffle_done),
    .card_req       (card_req),
    .card_valid     (card_valid),
    .card_value     (card_value),
    .player_total   (player_total),
    .dealer_total   (dealer_total),
    .player_cards   (player_cards),
    .state_code     (state_code),
    .result         (result)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic serve_card(input logic [3:0] v);
    int n;
    n = 0;
    while (card_req !== 1'b1 && n < 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (card_req !== 1'b1) begin
      check("card_req_wait", 32'(card_req), 32'd1);
    end else begin
      card_valid = 1'b1;
      card_value = v;
      @(negedge CLOCK_50);
      card_valid = 1'b0;
      card_value = 4'd0;
    end
  endtask

  task automatic wait_state(input string tag, input int s);
    int n;
    n = 0;
    while (int'(state_code) != s && n < 300) begin
      @(negedge CLOCK_50);
      n++;
    end
    check(tag, 32'(state_code), 32'(s));
  endtask

  task automatic give_shuffle_done();
    repeat (3) @(negedge CLOCK_50);
    shuffle_done = 1'b1;
    @(negedge CLOCK_50);
    shuffle_done = 1'b0;
  endtask

  task automatic deal(input logic [3:0] p1, input logic [3:0] d1,
                      input logic [3:0] p2, input logic [3:0] d2);
    serve_card(p1);
    serve_card(d1);
    serve_card(p2);
    serve_card(d2);
  endtask

  task automatic start_round(input string tag);
    new_game_pulse = 1'b1;
    @(negedge CLOCK_50);
    new_game_pulse = 1'b0;
    check({tag, "_clr_ptotal"}, 32'(player_total), 32'd0);
    check({tag, "_clr_result"}, 32'(result), 32'd0);
    check({tag, "_clr_state"}, 32'(state_code), S_SHUFFLE);
    @(negedge CLOCK_50);
    check({tag, "_shuffle_start"}, 32'(shuffle_start), 32'd1);
    give_shuffle_done();
  endtask

  initial begin
    // 1: reset state, shuffle, deal 10/6/7/10
    repeat (3) @(negedge CLOCK_50);
    check("rst_state", 32'(state_code), S_SHUFFLE);
    check("rst_card_req", 32'(card_req), 32'd0);
    check("rst_shuffle_start", 32'(shuffle_start), 32'd0);
    check("rst_totals", 32'({player_total, dealer_total}), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("t1_shuffle_pulse", 32'(shuffle_start), 32'd1);
    @(negedge CLOCK_50);
    check("t1_shuffle_pulse_end", 32'(shuffle_start), 32'd0);
    give_shuffle_done();
    deal(4'd10, 4'd6, 4'd7, 4'd10);
    wait_state("t1_player_turn", S_PTURN);
    check("t1_ptotal", 32'(player_total), 32'd17);
    check("t1_dtotal", 32'(dealer_total), 32'd16);
    check("t1_result", 32'(result), 32'd0);
    check("t1_pcards", 32'(player_cards), 32'd2);

    // 2: stay, dealer draws 5 -> 21, dealer wins
    stay_pulse = 1'b1;
    @(negedge CLOCK_50);
    stay_pulse = 1'b0;
    serve_card(4'd5);
    wait_state("t2_result_state", S_RESULT);
    check("t2_dtotal", 32'(dealer_total), 32'd21);
    check("t2_ptotal", 32'(player_total), 32'd17);
    check("t2_result", 32'(result), 32'd2);

    // 3: soft 20, hit 5 demotes ace to 15, dealer stands on 17
    start_round("t3");
    deal(4'd1, 4'd10, 4'd9, 4'd7);
    wait_state("t3_player_turn", S_PTURN);
    check("t3_soft_total", 32'(player_total), 32'd20);
    hit_pulse = 1'b1;
    @(negedge CLOCK_50);
    hit_pulse = 1'b0;
    serve_card(4'd5);
    wait_state("t3_back_to_turn", S_PTURN);
    check("t3_demoted_total", 32'(player_total), 32'd15);
    check("t3_pcards", 32'(player_cards), 32'd3);
    stay_pulse = 1'b1;
    @(negedge CLOCK_50);
    stay_pulse = 1'b0;
    wait_state("t3_result_state", S_RESULT);
    check("t3_dtotal", 32'(dealer_total), 32'd17);
    check("t3_result", 32'(result), 32'd2);

    // 4: player busts at 25, dealer never draws; pulses in RESULT ignored
    start_round("t4");
    deal(4'd10, 4'd10, 4'd6, 4'd8);
    wait_state("t4_player_turn", S_PTURN);
    hit_pulse = 1'b1;
    @(negedge CLOCK_50);
    hit_pulse = 1'b0;
    serve_card(4'd9);
    wait_state("t4_result_state", S_RESULT);
    check("t4_ptotal", 32'(player_total), 32'd25);
    check("t4_dtotal", 32'(dealer_total), 32'd18);
    check("t4_result", 32'(result), 32'd2);
    hit_pulse = 1'b1;
    @(negedge CLOCK_50);
    hit_pulse = 1'b0;
    stay_pulse = 1'b1;
    @(negedge CLOCK_50);
    stay_pulse = 1'b0;
    @(negedge CLOCK_50);
    check("t4_hold_state", 32'(state_code), S_RESULT);
    check("t4_hold_card_req", 32'(card_req), 32'd0);
    check("t4_hold_ptotal", 32'(player_total), 32'd25);
    check("t4_hold_result", 32'(result), 32'd2);

    // 5: simultaneous hit+stay -> stay; 18 vs 18 push
    start_round("t5");
    deal(4'd10, 4'd10, 4'd8, 4'd8);
    wait_state("t5_player_turn", S_PTURN);
    hit_pulse = 1'b1;
    stay_pulse = 1'b1;
    @(negedge CLOCK_50);
    hit_pulse = 1'b0;
    stay_pulse = 1'b0;
    check("t5_tie_state", 32'(state_code), S_DTURN);
    check("t5_tie_card_req", 32'(card_req), 32'd0);
    wait_state("t5_result_state", S_RESULT);
    check("t5_pcards", 32'(player_cards), 32'd2);
    check("t5_result", 32'(result), 32'd3);

    // 6: reset while dealer is mid-draw
    start_round("t6");
    deal(4'd10, 4'd10, 4'd8, 4'd2);
    wait_state("t6_player_turn", S_PTURN);
    stay_pulse = 1'b1;
    @(negedge CLOCK_50);
    stay_pulse = 1'b0;
    wait_state("t6_dealer_draw", S_DDRAW);
    check("t6_req_high", 32'(card_req), 32'd1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("t6_req_drop", 32'(card_req), 32'd0);
    check("t6_ptotal", 32'(player_total), 32'd0);
    check("t6_dtotal", 32'(dealer_total), 32'd0);
    check("t6_result", 32'(result), 32'd0);
    check("t6_state", 32'(state_code), S_SHUFFLE);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("t6_shuffle_pulse", 32'(shuffle_start), 32'd1);
    @(negedge CLOCK_50);
    check("t6_shuffle_once", 32'(shuffle_start), 32'd0);

    // 7: card value clamping and dealt 21 skipping the player turn
    give_shuffle_done();
    deal(4'd0, 4'd13, 4'd15, 4'd12);
    wait_state("t7_dealer_turn", S_DTURN);
    check("t7_blackjack", 32'(player_total), 32'd21);
    check("t7_dtotal", 32'(dealer_total), 32'd20);
    wait_state("t7_result_state", S_RESULT);
    check("t7_result", 32'(result), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
